// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Seven-segment glyph constants, bit positions and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_B  = 6;
    localparam int SEG_BIT_C  = 5;
    localparam int SEG_BIT_D  = 4;
    localparam int SEG_BIT_E  = 3;
    localparam int SEG_BIT_F  = 2;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

    // Glyphs as lit segments a..g (bit 6 = a)
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    // Raw active-low byte of a dark digit
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic       known;
        logic [3:0] digit;
        logic       dp;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [7:0] seg_n);
        logic [7:0] w_on;
        logic [6:0] w_glyph;
        seg_dec_t   w_res;
        w_on        = ~seg_n;
        w_glyph     = w_on[SEG_BIT_A:SEG_BIT_G];
        w_res.dp    = w_on[SEG_BIT_DP];
        w_res.known = 1'b1;
        w_res.digit = 4'h0;
        case (w_glyph)
            SEG_0:   w_res.digit = 4'h0;
            SEG_1:   w_res.digit = 4'h1;
            SEG_2:   w_res.digit = 4'h2;
            SEG_3:   w_res.digit = 4'h3;
            SEG_4:   w_res.digit = 4'h4;
            SEG_5:   w_res.digit = 4'h5;
            SEG_6:   w_res.digit = 4'h6;
            SEG_7:   w_res.digit = 4'h7;
            SEG_8:   w_res.digit = 4'h8;
            SEG_9:   w_res.digit = 4'h9;
            SEG_A:   w_res.digit = 4'hA;
            SEG_B:   w_res.digit = 4'hB;
            SEG_C:   w_res.digit = 4'hC;
            SEG_D:   w_res.digit = 4'hD;
            SEG_E:   w_res.digit = 4'hE;
            SEG_F:   w_res.digit = 4'hF;
            default: w_res.known = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_reader_if
// Description : Valid/ready stream of per-digit display change events.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_reader_if;
    logic       upd_valid;
    logic       upd_ready;
    logic [2:0] upd_idx;
    logic [3:0] upd_digit;
    logic       upd_known;
    logic       upd_dp;

    modport master (
        output upd_valid, upd_idx, upd_digit, upd_known, upd_dp,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_idx, upd_digit, upd_known, upd_dp,
        output upd_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg_stab.sv
`default_nettype none
// ============================================================================
// Module      : seg_stab
// Description : Single-digit stability filter; commits a byte once it has
//               been sampled STABLE_CYCLES times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_stab
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] i_sample,
    output logic            o_commit,
    output logic [7:0]      o_committed
);

    localparam logic [7:0] c_cnt_max = 8'(STABLE_CYCLES);

    logic [7:0] r_cand;
    logic [7:0] r_cnt;
    logic [7:0] r_committed;
    logic [7:0] w_cand_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_same;

    assign w_same     = (i_sample == r_cand);
    assign w_cand_nxt = w_same ? r_cand : i_sample;
    assign w_cnt_nxt  = !w_same ? 8'd1 :
                        (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 8'd1;

    // Fires on the edge the count reaches threshold, only for a new byte
    assign o_commit   = (w_cnt_nxt == c_cnt_max) && (w_cand_nxt != r_committed);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand      <= SEG_BLANK;
            r_cnt       <= c_cnt_max;
            r_committed <= SEG_BLANK;
        end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (o_commit) begin
                r_committed <= w_cand_nxt;
            end
        end
    end

    assign o_committed = r_committed;

endmodule
`default_nettype wire

// File: rtl/seg_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg_reader
// Description : Eight-digit seven-segment observer: filters, decodes and
//               emits round-robin change events on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [7:0]  i_seg1,
    input  wire logic [7:0]  i_seg2,
    input  wire logic [7:0]  i_seg3,
    input  wire logic [7:0]  i_seg4,
    input  wire logic [7:0]  i_seg5,
    input  wire logic [7:0]  i_seg6,
    input  wire logic [7:0]  i_seg7,
    input  wire logic [7:0]  i_seg8,
    output logic [31:0]      o_digits,
    output logic [7:0]       o_known,
    output logic [7:0]       o_dp,
    seg_reader_if.master     upd
);

    logic [7:0] w_seg       [8];
    logic [7:0] w_committed [8];
    seg_dec_t   w_dec       [8];
    logic [7:0] w_commit;

    logic [7:0] r_pending;
    logic [2:0] r_ptr;
    logic       r_valid;
    logic [2:0] r_idx;
    logic [3:0] r_digit;
    logic       r_known;
    logic       r_dp;

    logic       w_found;
    logic [2:0] w_sel;
    logic       w_load;
    logic [7:0] w_clr;

    assign w_seg[0] = i_seg1;
    assign w_seg[1] = i_seg2;
    assign w_seg[2] = i_seg3;
    assign w_seg[3] = i_seg4;
    assign w_seg[4] = i_seg5;
    assign w_seg[5] = i_seg6;
    assign w_seg[6] = i_seg7;
    assign w_seg[7] = i_seg8;

    // The live image is decoded straight from the committed bytes
    for (genvar g = 0; g < 8; g++) begin : g_digit
        seg_stab #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_stab (
            .clk         (clk),
            .rst         (rst),
            .i_sample    (w_seg[g]),
            .o_commit    (w_commit[g]),
            .o_committed (w_committed[g])
        );

        assign w_dec[g]          = seg_decode(w_committed[g]);
        assign o_digits[4*g +: 4] = w_dec[g].digit;
        assign o_known[g]        = w_dec[g].known;
        assign o_dp[g]           = w_dec[g].dp;
    end

    // Round-robin pick: first pending index after the last one emitted
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        for (int off = 1; off <= 8; off++) begin
            logic [2:0] w_idx;
            w_idx = r_ptr + 3'(off);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_load = w_found && (!r_valid || upd.upd_ready);
    assign w_clr  = w_load ? (8'b1 << w_sel) : 8'b0;

    // A commit landing on the digit being loaded keeps its pending bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 8'b0;
            r_ptr     <= 3'd7;
            r_valid   <= 1'b0;
            r_idx     <= 3'd0;
            r_digit   <= 4'd0;
            r_known   <= 1'b0;
            r_dp      <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_commit;
            if (w_load) begin
                r_valid <= 1'b1;
                r_idx   <= w_sel;
                r_digit <= w_dec[w_sel].digit;
                r_known <= w_dec[w_sel].known;
                r_dp    <= w_dec[w_sel].dp;
                r_ptr   <= w_sel;
            end else if (upd.upd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign upd.upd_valid = r_valid;
    assign upd.upd_idx   = r_idx;
    assign upd.upd_digit = r_digit;
    assign upd.upd_known = r_known;
    assign upd.upd_dp    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_reader
// Description : Directed self-checking bench for seg_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg [8];
    logic [31:0] digits;
    logic [7:0]  known;
    logic [7:0]  dp;
    int          errors = 0;
    int          checks = 0;
    logic        seen;

    logic [6:0] gly [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_reader_if u_if ();

    seg_reader #(
        .STABLE_CYCLES (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_seg1   (seg[0]),
        .i_seg2   (seg[1]),
        .i_seg3   (seg[2]),
        .i_seg4   (seg[3]),
        .i_seg5   (seg[4]),
        .i_seg6   (seg[5]),
        .i_seg7   (seg[6]),
        .i_seg8   (seg[7]),
        .o_digits (digits),
        .o_known  (known),
        .o_dp     (dp),
        .upd      (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input int v, input logic p);
        return ~{gly[v], p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [2:0] idx, input logic [3:0] dg,
                             input logic kn, input logic p);
        check({tag, "_valid"}, 32'(u_if.upd_valid), 32'd1);
        check({tag, "_idx"},   32'(u_if.upd_idx),   32'(idx));
        check({tag, "_digit"}, 32'(u_if.upd_digit), 32'(dg));
        check({tag, "_known"}, 32'(u_if.upd_known), 32'(kn));
        check({tag, "_dp"},    32'(u_if.upd_dp),    32'(p));
    endtask

    initial begin
        // Reset and idle display
        rst = 1'b1;
        u_if.upd_ready = 1'b0;
        for (int i = 0; i < 8; i++) seg[i] = 8'hFF;
        tick();
        tick();
        rst = 1'b0;
        check("rst_digits", digits, 32'h0);
        check("rst_known", 32'(known), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_valid", 32'(u_if.upd_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (u_if.upd_valid) seen = 1'b1;
        end
        check("idle_quiet", 32'(seen), 32'h0);

        // Commit latency: '2' on digit 2
        seg[2] = 8'h25;
        tick();
        tick();
        tick();
        check("lat_early", 32'(digits[11:8]), 32'h0);
        tick();
        check("lat_digit", 32'(digits[11:8]), 32'h2);
        check("lat_known", 32'(known), 32'h04);
        check("lat_novalid", 32'(u_if.upd_valid), 32'h0);
        tick();
        check_evt("lat_evt", 3'd2, 4'h2, 1'b1, 1'b0);
        u_if.upd_ready = 1'b1;
        tick();
        u_if.upd_ready = 1'b0;
        check("lat_drained", 32'(u_if.upd_valid), 32'h0);

        // Short glitch on digit 0
        seen = 1'b0;
        seg[0] = 8'h9F;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (u_if.upd_valid || digits != 32'h0000_0200) seen = 1'b1;
        end
        seg[0] = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (u_if.upd_valid || digits != 32'h0000_0200) seen = 1'b1;
        end
        check("glitch_quiet", 32'(seen), 32'h0);
        check("glitch_digits", digits, 32'h0000_0200);
        check("glitch_known", 32'(known), 32'h04);

        // Unknown glyph with decimal point on digit 4, left undelivered
        seg[4] = 8'h7E;
        for (int i = 0; i < 4; i++) tick();
        check("unk_known", 32'(known), 32'h04);
        check("unk_dp", 32'(dp), 32'h10);
        check("unk_digit", 32'(digits[19:16]), 32'h0);
        tick();
        check_evt("unk_evt", 3'd4, 4'h0, 1'b0, 1'b1);

        // Mid-operation reset drops the event; all digits change together
        rst = 1'b1;
        for (int i = 0; i < 8; i++) seg[i] = enc(15 - i, 1'(i % 2));
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(u_if.upd_valid), 32'h0);
        check("mrst_digits", digits, 32'h0);
        check("mrst_known", 32'(known), 32'h0);
        check("mrst_dp", 32'(dp), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("rr_digits", digits, 32'h89AB_CDEF);
        check("rr_known", 32'(known), 32'hFF);
        check("rr_dp", 32'(dp), 32'hAA);
        check("rr_novalid", 32'(u_if.upd_valid), 32'h0);
        tick();
        for (int c = 0; c < 10; c++) begin
            check_evt("rr_hold", 3'd0, 4'hF, 1'b1, 1'b0);
            tick();
        end
        u_if.upd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_evt("rr_seq", 3'(i), 4'(15 - i), 1'b1, 1'(i % 2));
            tick();
        end
        check("rr_done", 32'(u_if.upd_valid), 32'h0);
        u_if.upd_ready = 1'b0;

        // Coalescing: digit 0 goes 1 then 7 while digit 1's event is stalled
        seg[1] = enc(2, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_evt("co_block", 3'd1, 4'h2, 1'b1, 1'b0);
        seg[0] = enc(1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("co_first", 32'(digits[3:0]), 32'h1);
        seg[0] = enc(7, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("co_second", 32'(digits[3:0]), 32'h7);
        check_evt("co_still", 3'd1, 4'h2, 1'b1, 1'b0);
        u_if.upd_ready = 1'b1;
        tick();
        check_evt("co_evt", 3'd0, 4'h7, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (u_if.upd_valid) seen = 1'b1;
        end
        check("co_single", 32'(seen), 32'h0);
        u_if.upd_ready = 1'b0;

        // Commit of digit 0 on the same edge it is loaded
        seg[2] = enc(5, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_evt("sc_block", 3'd2, 4'h5, 1'b1, 1'b0);
        seg[0] = enc(3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_evt("sc_still", 3'd2, 4'h5, 1'b1, 1'b0);
        seg[0] = enc(9, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        u_if.upd_ready = 1'b1;
        tick();
        check_evt("sc_old", 3'd0, 4'h3, 1'b1, 1'b0);
        check("sc_image", 32'(digits[3:0]), 32'h9);
        tick();
        check_evt("sc_new", 3'd0, 4'h9, 1'b1, 1'b0);
        tick();
        check("sc_done", 32'(u_if.upd_valid), 32'h0);
        u_if.upd_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
